// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Up/down binary counter with a registered Gray-code output.
//                Intended as the source side of a clock-domain crossing,
//                for example an async FIFO read or write pointer. The far
//                side decodes the Gray value back to binary.
//
//  Ports       : clk       - system clock, all state changes on rising edge
//                rst       - synchronous, active-high reset
//                en        - count enable, one step per cycle while high
//                up        - direction, 1 = increment, 0 = decrement
//                load      - synchronous load strobe (overrides en)
//                load_bin  - binary value taken when load is high
//                bin       - registered binary count
//                gray      - registered Gray code of bin
//                wrap      - one-cycle pulse, the last step wrapped
//                            modulo 2^WIDTH
//
//  Parameters  : WIDTH     - counter and code width in bits, legal 2..16
//
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_wrap_nxt;

    // Next binary value and wrap flag. Priority below reset is
    // load > en > hold. A wrap is detected on the value being left,
    // not the value being entered, so it marks the step itself.
    always_comb begin
        w_bin_nxt  = r_bin;
        w_wrap_nxt = 1'b0;
        if (load) begin
            w_bin_nxt = load_bin;
        end else if (en) begin
            if (up) begin
                w_bin_nxt  = r_bin + c_one;
                w_wrap_nxt = &r_bin;
            end else begin
                w_bin_nxt  = r_bin - c_one;
                w_wrap_nxt = (r_bin == c_zero);
            end
        end
    end

    // Gray encoding is taken from the next binary value so the gray pin is
    // driven straight from a flop, with no logic after the register that
    // could glitch in front of a synchroniser.
    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bin  = r_bin;
    assign gray = r_gray;
    assign wrap = r_wrap;

endmodule
`default_nettype wire
